// File: rtl/n64_cmd_tx.sv
// N64 joybus command transmitter: serialises 1..MAX_BYTES command bytes (byte 0 first,
// MSB first) plus one stop bit, using a low / data / high slot waveform.
module n64_cmd_tx #(
    parameter int T_LOW     = 100,
    parameter int T_DATA    = 300,
    parameter int T_BIT     = 400,
    parameter int MAX_BYTES = 4,
    parameter int LW        = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*MAX_BYTES-1:0] cmd_data,
    input  logic [LW-1:0]          cmd_len,
    input  logic                   start,
    output logic                   data_out,
    output logic                   writing_data,
    output logic                   done,
    output logic                   len_err
);
    localparam int SW = $clog2(T_BIT);
    localparam int BW = $clog2(8 * MAX_BYTES + 1);
    localparam int DW = 8 * MAX_BYTES;

    typedef enum logic [1:0] {IDLE, SEND, STOP} state_t;

    state_t          state, state_d;
    logic [SW-1:0]   slot_cnt, slot_d;
    logic [BW-1:0]   bit_idx, bit_d;
    logic [DW-1:0]   shreg, sh_d;
    logic [LW-1:0]   len, len_d;
    logic [DW-1:0]   ordered;
    logic            data_d, writing_d, done_d, len_err_d;
    logic            legal, slot_end, last_bit, bit_val;

    // Reorder so the shift register MSB is always the next bit on the wire.
    always_comb begin
        ordered = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            ordered[DW-1-8*k -: 8] = cmd_data[8*k +: 8];
        end
    end

    assign legal    = (cmd_len != '0) && (cmd_len <= LW'(MAX_BYTES));
    assign slot_end = (slot_cnt == SW'(T_BIT - 1));
    assign last_bit = (bit_idx == (BW'({len, 3'b000}) - BW'(1)));

    always_comb begin
        state_d   = state;
        slot_d    = slot_cnt;
        bit_d     = bit_idx;
        sh_d      = shreg;
        len_d     = len;
        done_d    = 1'b0;
        len_err_d = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (legal) begin
                        state_d = SEND;
                        slot_d  = '0;
                        bit_d   = '0;
                        sh_d    = ordered;
                        len_d   = cmd_len;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (slot_end) begin
                    slot_d = '0;
                    if (last_bit) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_idx + 1'b1;
                        sh_d  = {shreg[DW-2:0], 1'b0};
                    end
                end else begin
                    slot_d = slot_cnt + 1'b1;
                end
            end
            STOP: begin
                if (slot_end) begin
                    slot_d  = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    slot_d = slot_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is derived from next-cycle state so the register tracks slot_cnt exactly.
        bit_val   = (state_d == SEND) ? sh_d[DW-1] : 1'b1;
        writing_d = (state_d != IDLE);
        if (!writing_d) begin
            data_d = 1'b1;
        end else if (slot_d < SW'(T_LOW)) begin
            data_d = 1'b0;
        end else if (slot_d < SW'(T_DATA)) begin
            data_d = bit_val;
        end else begin
            data_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            slot_cnt     <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            len          <= '0;
            data_out     <= 1'b1;
            writing_data <= 1'b0;
            done         <= 1'b0;
            len_err      <= 1'b0;
        end else begin
            state        <= state_d;
            slot_cnt     <= slot_d;
            bit_idx      <= bit_d;
            shreg        <= sh_d;
            len          <= len_d;
            data_out     <= data_d;
            writing_data <= writing_d;
            done         <= done_d;
            len_err      <= len_err_d;
        end
    end
endmodule

// File: tb/tb_n64_cmd_tx.sv
// Bench for n64_cmd_tx: two configurations checked every cycle against a frame-position model.
module tb_n64_cmd_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start0 = 1'b0;
    logic [2:0]  len0 = '0;
    logic [31:0] data0 = '0;
    logic        do0, wd0, dn0, er0;
    logic        start1 = 1'b0;
    logic [1:0]  len1 = '0;
    logic [15:0] data1 = '0;
    logic        do1, wd1, dn1, er1;

    n64_cmd_tx dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_data(data0), .cmd_len(len0), .start(start0),
        .data_out(do0), .writing_data(wd0), .done(dn0), .len_err(er0)
    );

    n64_cmd_tx #(.T_LOW(2), .T_DATA(6), .T_BIT(8), .MAX_BYTES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_data(data1), .cmd_len(len1), .start(start1),
        .data_out(do1), .writing_data(wd1), .done(dn1), .len_err(er1)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a frame is just a cycle position p; slot = p / T_BIT, phase = p % T_BIT.
    int          tlow[2]  = '{100, 2};
    int          tdata[2] = '{300, 6};
    int          tbit[2]  = '{400, 8};
    int          maxb[2]  = '{4, 2};
    bit          m_act[2];
    bit          m_done[2];
    bit          m_err[2];
    int          m_p[2];
    int          m_len[2];
    logic [63:0] m_dat[2];

    task automatic model_step(input int i, input logic st, input int len, input logic [63:0] d);
        m_done[i] = 1'b0;
        m_err[i]  = 1'b0;
        if (m_act[i]) begin
            if (m_p[i] == (8 * m_len[i] + 1) * tbit[i] - 1) begin
                m_act[i]  = 1'b0;
                m_done[i] = 1'b1;
            end else begin
                m_p[i]++;
            end
        end else if (st) begin
            if (len >= 1 && len <= maxb[i]) begin
                m_act[i] = 1'b1;
                m_p[i]   = 0;
                m_len[i] = len;
                m_dat[i] = d;
            end else begin
                m_err[i] = 1'b1;
            end
        end
    endtask

    function automatic logic lvl(input int i);
        int slot, c;
        if (!m_act[i]) return 1'b1;
        slot = m_p[i] / tbit[i];
        c    = m_p[i] % tbit[i];
        if (c < tlow[i]) return 1'b0;
        if (c < tdata[i]) begin
            if (slot < 8 * m_len[i]) return m_dat[i][8 * (slot / 8) + 7 - (slot % 8)];
            return 1'b1;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 1'b0; m_done[i] = 1'b0; m_err[i] = 1'b0; m_p[i] = 0;
            end
        end else begin
            model_step(0, start0, int'(len0), {32'b0, data0});
            model_step(1, start1, int'(len1), {48'b0, data1});
        end
    end

    logic tr0[0:16383];
    logic tr1[0:1023];
    int   run0 = 0, last0 = 0, run1 = 0, last1 = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk1("data_out0", do0, lvl(0));
            chk1("writing0", wd0, m_act[0]);
            chk1("done0", dn0, m_done[0]);
            chk1("len_err0", er0, m_err[0]);
            chk1("data_out1", do1, lvl(1));
            chk1("writing1", wd1, m_act[1]);
            chk1("done1", dn1, m_done[1]);
            chk1("len_err1", er1, m_err[1]);
            if (wd0) begin
                if (run0 < 16384) tr0[run0] = do0;
                run0++;
            end else if (run0 != 0) begin
                last0 = run0; run0 = 0;
            end
            if (wd1) begin
                if (run1 < 1024) tr1[run1] = do1;
                run1++;
            end else if (run1 != 0) begin
                last1 = run1; run1 = 0;
            end
        end
    end

    task automatic go0(input logic [2:0] l, input logic [31:0] d);
        @(negedge clk);
        start0 = 1'b1; len0 = l; data0 = d;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic go1(input logic [1:0] l, input logic [15:0] d);
        @(negedge clk);
        start1 = 1'b1; len1 = l; data1 = d;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int i, input int limit);
        int n = 0;
        while (((i == 0) ? dn0 : dn1) !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk1((i == 0) ? "done0_reached" : "done1_reached", n < limit, 1'b1);
    endtask

    initial begin
        #12;
        chk1("rst_do0", do0, 1'b1);
        chk1("rst_wd0", wd0, 1'b0);
        chk1("rst_done0", dn0, 1'b0);
        chk1("rst_err0", er0, 1'b0);
        chk1("rst_do1", do1, 1'b1);
        chk1("rst_wd1", wd1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a frame
        go0(3'd1, 32'h0);
        repeat (498) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk1("midrst_do0", do0, 1'b1);
        chk1("midrst_wd0", wd0, 1'b0);
        chk1("midrst_done0", dn0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single status byte 0x00
        go0(3'd1, 32'h0);
        wait_done(0, 5000);
        @(negedge clk);
        chkn("len_status", last0, 3600);
        chk1("st_c50", tr0[50], 1'b0);
        chk1("st_c299", tr0[299], 1'b0);
        chk1("st_c300", tr0[300], 1'b1);
        chk1("st_stop_low", tr0[3299], 1'b0);
        chk1("st_stop_high", tr0[3300], 1'b1);

        // Three bytes 02 80 FF
        go0(3'd3, 32'h00FF8002);
        wait_done(0, 12000);
        @(negedge clk);
        chkn("len_3byte", last0, 10000);
        chk1("mb_slot6", tr0[6*400+200], 1'b1);
        chk1("mb_slot7", tr0[7*400+200], 1'b0);
        chk1("mb_slot8", tr0[8*400+200], 1'b1);
        chk1("mb_slot9", tr0[9*400+200], 1'b0);
        chk1("mb_slot16", tr0[16*400+200], 1'b1);
        chk1("mb_slot23", tr0[23*400+250], 1'b1);
        chk1("mb_stop_low", tr0[24*400+50], 1'b0);
        chk1("mb_stop_high", tr0[24*400+200], 1'b1);

        // Illegal lengths
        @(negedge clk);
        start0 = 1'b1; len0 = 3'd0;
        @(negedge clk);
        start0 = 1'b0;
        chk1("err_len0", er0, 1'b1);
        chk1("err_len0_wd", wd0, 1'b0);
        @(negedge clk);
        start0 = 1'b1; len0 = 3'd5;
        @(negedge clk);
        start0 = 1'b0;
        chk1("err_len5", er0, 1'b1);
        chk1("err_len5_do", do0, 1'b1);

        // Start while busy is ignored, then back-to-back on the done cycle
        go0(3'd1, $urandom);
        repeat (1000) @(negedge clk);
        start0 = 1'b1; len0 = 3'd2; data0 = $urandom;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, 5000);
        start0 = 1'b1; len0 = 3'd1; data0 = $urandom;
        @(negedge clk);
        start0 = 1'b0;
        chk1("b2b_wd0", wd0, 1'b1);
        chkn("busy_len", last0, 3600);
        wait_done(0, 5000);
        @(negedge clk);

        // Random frames on the default configuration
        repeat (2) begin
            go0(3'($urandom_range(1, 2)), $urandom);
            wait_done(0, 8000);
            @(negedge clk);
        end

        // Small-timing configuration, bytes A5 3C
        go1(2'd2, 16'h3CA5);
        wait_done(1, 500);
        @(negedge clk);
        chkn("len_small", last1, 136);
        chk1("sm_s0_low", tr1[0], 1'b0);
        chk1("sm_s0_bit", tr1[3], 1'b1);
        chk1("sm_s1_bit", tr1[8+3], 1'b0);
        chk1("sm_s1_high", tr1[8+6], 1'b1);
        chk1("sm_s8_bit", tr1[64+3], 1'b0);
        chk1("sm_s10_bit", tr1[80+3], 1'b1);
        chk1("sm_stop_low", tr1[128+1], 1'b0);
        chk1("sm_stop_bit", tr1[128+3], 1'b1);

        // Random starts, lengths and data, including illegal and busy-time starts
        repeat (4000) begin
            @(negedge clk);
            start1 = ($urandom_range(0, 15) == 0);
            len1   = 2'($urandom);
            data1  = 16'($urandom);
        end
        start1 = 1'b0;
        repeat (200) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
